// File: rtl/shift_in_param.sv
// Serial-to-parallel receiver: edge-started word capture with abort/restart.
// Optional even-parity bit after the data word when SHIFT_IN_PARITY_EN is defined.
module shift_in_param #(
  parameter int WIDTH     = 12,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       x_in,
  input  logic                       sx,
  output logic [WIDTH-1:0]           x_parallel,
  output logic                       fx,
  output logic                       busy,
`ifdef SHIFT_IN_PARITY_EN
  output logic                       parity_err,
`endif
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
`ifdef SHIFT_IN_PARITY_EN
  localparam logic [1:0] PARITY = 2'd3;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             sx_d;
  logic             start;

  assign start = sx & ~sx_d;

  // Next shift-register value; first bit ends up at the end chosen by MSB_FIRST.
  always_comb begin
    sr_next = sr;
    if (MSB_FIRST)
      sr_next = {sr[WIDTH-2:0], x_in};
    else
      sr_next = {x_in, sr[WIDTH-1:1]};
  end

  // Word sequencer; a start edge always restarts the word from scratch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      sr         <= '0;
      x_parallel <= '0;
      count      <= '0;
      fx         <= 1'b0;
      busy       <= 1'b0;
      sx_d       <= 1'b1;
`ifdef SHIFT_IN_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      sx_d <= sx;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= SHIFT;
            sr    <= '0;
            count <= '0;
            busy  <= 1'b1;
            fx    <= 1'b0;
          end
        end
        SHIFT: begin
          if (start) begin
            sr    <= '0;
            count <= '0;
          end else if (count == LAST) begin
            count <= FULL;
`ifdef SHIFT_IN_PARITY_EN
            sr    <= sr_next;
            state <= PARITY;
`else
            sr         <= '0;
            x_parallel <= sr_next;
            fx         <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
`endif
          end else begin
            sr    <= sr_next;
            count <= count + ONE;
          end
        end
`ifdef SHIFT_IN_PARITY_EN
        PARITY: begin
          if (start) begin
            sr    <= '0;
            count <= '0;
            state <= SHIFT;
          end else begin
            x_parallel <= sr;
            parity_err <= ^{sr, x_in};
            sr         <= '0;
            fx         <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end
        end
`endif
        default: begin
          state <= IDLE;
          sr    <= '0;
          count <= '0;
          fx    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_in_param.md
SHIFT_IN_PARAM -- requirements
Module: shift_in_param

Interface
- REQ-001: Parameter WIDTH, default 12: number of serial data bits per word; legal range 2..32.
- REQ-002: Parameter MSB_FIRST, default 1: 1 = first received bit lands in x_parallel[WIDTH-1]; 0 = first received bit lands in x_parallel[0].
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: reset  input  1  one clock; reset is synchronous and active-low.
- REQ-005: x_in  input  1  serial data, sampled on rising clk while shifting.
- REQ-006: sx  input  1  start request; a rising edge (low on previous sampled edge, high on current) starts a word.
- REQ-007: x_parallel  output  WIDTH  last completed word; registered.
- REQ-008: fx  output  1  word-complete flag; registered.
- REQ-009: busy  output  1  high while in SHIFT state; registered.
- REQ-010: count  output  $clog2(WIDTH+1)  bits captured in current word.

Function
- REQ-011: Internal register sx_d holds sx from the previous edge; start = sx & ~sx_d; level-high sx never retriggers.
- REQ-012: States: IDLE, SHIFT, DONE (plus PARITY when the REQ-024 macro is defined); unused encodings go to IDLE on the next edge.
- REQ-013: IDLE: on an edge with start=1, go to SHIFT, count=0, busy=1, fx=0; otherwise hold.
- REQ-014: SHIFT: each edge shifts x_in into an internal shift register and increments count; the shift direction follows MSB_FIRST.
- REQ-015: SHIFT, edge where count==WIDTH-1 and start=0: capture the completed word into x_parallel, go to DONE, fx=1, busy=0, count=WIDTH.
- REQ-016: Latency: start detected at edge k; bits sampled at edges k+1..k+WIDTH; x_parallel valid and fx=1 after edge k+WIDTH.
- REQ-017: x_parallel changes only on completion (REQ-015); it holds the previous word throughout SHIFT.
- REQ-018: DONE: fx held high and x_parallel held until start=1. Start then goes to SHIFT with count=0, fx=0, and x_parallel unchanged.
- REQ-019: Start during SHIFT, including at the count==WIDTH-1 edge, aborts the word. Partial bits are discarded, count=0, state stays SHIFT, and x_parallel is not updated.
- REQ-020: count saturates at WIDTH; it never wraps.

Reset
- REQ-021: On an edge with reset=0, the block goes to IDLE with x_parallel=0, shift register=0, count=0, fx=0, busy=0, and sx_d=1. sx_d=1 ensures sx held high through reset does not start a word.
- REQ-022: Reset mid-SHIFT or in DONE has priority over all other events and discards data.
- REQ-023: While reset=0, the x_in and sx inputs are ignored.

Configuration
- REQ-024: Macro SHIFT_IN_PARITY_EN defined: after the WIDTH data bits, one extra even-parity bit is sampled in state PARITY. fx then asserts one edge later (after edge k+WIDTH+1).
- REQ-025: SHIFT_IN_PARITY_EN defined: an added output parity_err (1 bit, reset 0) is registered with fx. It is 1 when the XOR of the data bits and the parity bit is 1; x_parallel is updated regardless.
- REQ-026: SHIFT_IN_PARITY_EN defined: start during PARITY aborts exactly as in REQ-019.
- REQ-027: SHIFT_IN_PARITY_EN undefined: no PARITY state and no parity_err port; behaviour is per REQ-011..020.

Verification
- REQ-028: WIDTH=12, MSB_FIRST=1, sx rises, serial 1010_1100_0011 -> after 12 shift edges x_parallel=12'hAC3, fx=1, busy=0, count=12.
- REQ-029: WIDTH=8, MSB_FIRST=0, serial 1,0,0,0,0,0,0,0 -> x_parallel=8'h01; with MSB_FIRST=1 the same stream -> x_parallel=8'h80.
- REQ-030: Word 12'hAC3 done, then sx re-rises and 5 bits are shifted -> fx=0 and x_parallel stays 12'hAC3 until the new word completes.
- REQ-031: sx rises again at count=7 -> count=0, the previous x_parallel is retained, and the next 12 bits form the word; sx held high for 30 cycles produces exactly one word.
- REQ-032: reset=0 at count=6, sx held high through reset release -> IDLE, all outputs 0, no word starts until sx falls and rises.
- REQ-033: SHIFT_IN_PARITY_EN, WIDTH=8, data 8'h07 with parity bit 1 -> fx after 9 shift edges, parity_err=0; the same data with parity bit 0 -> parity_err=1.
